// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and boot image for the scanned data memory
package data_mem_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   localparam int BOOT_IMAGE_WORDS = 16;

   // Boot image; indices beyond the table read as zero.
   function automatic logic [7:0] boot_image_word(input int unsigned idx);
      logic [7:0] w_word;
      case (idx)
         0:       w_word = 8'd7;
         1:       w_word = 8'd3;
         2:       w_word = 8'd2;
         3:       w_word = 8'd1;
         4:       w_word = 8'd6;
         5:       w_word = 8'd4;
         6:       w_word = 8'd5;
         7:       w_word = 8'd8;
         8:       w_word = 8'd7;
         default: w_word = 8'd0;
      endcase
      return w_word;
   endfunction

endpackage

// File: rtl/mem_scan_counter.sv
// rtl/mem_scan_counter.sv - prescaled wrap-around word index for the display scan
module mem_scan_counter #(
   parameter int ADDR_W   = 4,
   parameter int SCAN_DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] scan_addr
);

   localparam int PW = $clog2(SCAN_DIV + 1);

   logic [PW-1:0]     r_presc;
   logic [ADDR_W-1:0] r_scan_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc     <= '0;
         r_scan_addr <= '0;
      end else if (r_presc == PW'(SCAN_DIV - 1)) begin
         r_presc     <= '0;
         r_scan_addr <= r_scan_addr + 1'b1;
      end else begin
         r_presc     <= r_presc + 1'b1;
      end
   end

   assign scan_addr = r_scan_addr;

endmodule

// File: rtl/data_mem_scan.sv
// rtl/data_mem_scan.sv - single-port data memory with boot image, clear,
// registered-read handshake and rotating display scan
module data_mem_scan
   import data_mem_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter int BOOT_EN  = 1,
   parameter int SCAN_DIV = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic                           req_we,
   input  logic [ADDR_W-1:0]              req_addr,
   input  logic [DATA_W-1:0]              req_wdata,
   output logic                           rsp_valid,
   output logic [DATA_W-1:0]              rsp_rdata,
   input  logic                           clr_req,
   output logic                           busy,
   output logic [ADDR_W-1:0]              scan_addr,
   output logic [DATA_W-1:0]              scan_data,
   output logic [(2**ADDR_W)*DATA_W-1:0]  data_output
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_fill_ptr, w_fill_ptr_nxt;
   logic              w_fill_we;
   logic [DATA_W-1:0] w_fill_data;
   logic [7:0]        w_boot_byte;
   logic              w_fire;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;

   assign req_ready   = (r_state == ST_IDLE);
   assign busy        = ~req_ready;
   assign w_fire      = req_valid & req_ready;
   assign w_boot_byte = boot_image_word(32'(r_fill_ptr));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_BOOT;
         r_fill_ptr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_fill_ptr <= w_fill_ptr_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_fill_ptr_nxt = r_fill_ptr;
      w_fill_we      = 1'b0;
      w_fill_data    = '0;
      case (r_state)
         ST_BOOT, ST_CLEAR: begin
            w_fill_we      = 1'b1;
            w_fill_data    = (r_state == ST_BOOT && BOOT_EN != 0) ? DATA_W'(w_boot_byte) : '0;
            w_fill_ptr_nxt = r_fill_ptr + 1'b1;
            if (r_fill_ptr == ADDR_W'(DEPTH - 1))
               w_state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (clr_req) begin
               w_state_nxt    = ST_CLEAR;
               w_fill_ptr_nxt = '0;
            end
         end
         default: w_state_nxt = ST_BOOT;
      endcase
   end

   // Array carries no reset; writes are simply suppressed while rst is held.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_fill_we)
            r_mem[r_fill_ptr] <= w_fill_data;
         else if (w_fire && req_we)
            r_mem[req_addr] <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= w_fire & ~req_we;
         if (w_fire && !req_we)
            r_rsp_rdata <= r_mem[req_addr];
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;

   mem_scan_counter #(
      .ADDR_W   (ADDR_W),
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk       (clk),
      .rst       (rst),
      .scan_addr (scan_addr)
   );

   assign scan_data = r_mem[scan_addr];

   always_comb begin
      data_output = '0;
      for (int i = 0; i < DEPTH; i++)
         data_output[i*DATA_W +: DATA_W] = r_mem[i];
   end

endmodule

// File: tb/tb_data_mem_scan.sv
// tb/tb_data_mem_scan.sv - self-checking bench for data_mem_scan
module tb_data_mem_scan;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int SDIV  = 4;

   localparam int M_BOOT  = 0;
   localparam int M_IDLE  = 1;
   localparam int M_CLEAR = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [AW-1:0]     req_addr = '0;
   logic [DW-1:0]     req_wdata = '0;
   logic              rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic              clr_req = 1'b0;
   logic              busy;
   logic [AW-1:0]     scan_addr;
   logic [DW-1:0]     scan_data;
   logic [DEPTH*DW-1:0] data_output;

   int checks = 0;
   int errors = 0;

   int img [DEPTH] = '{7, 3, 2, 1, 6, 4, 5, 8, 7, 0, 0, 0, 0, 0, 0, 0};

   data_mem_scan #(.DATA_W(DW), .ADDR_W(AW), .BOOT_EN(1), .SCAN_DIV(SDIV)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .clr_req(clr_req),
      .busy(busy), .scan_addr(scan_addr), .scan_data(scan_data),
      .data_output(data_output)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DEPTH*DW-1:0] act, input logic [DEPTH*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: memory image, mode, words filled, response, cycles since reset.
   int m_mem [DEPTH];
   bit m_known [DEPTH];
   int m_mode = M_BOOT;
   int m_cnt = 0;
   bit m_rsp_valid = 0;
   int m_rsp_rdata = 0;
   int m_cycles = 0;
   bit m_init = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_init = 1;
         m_mode = M_BOOT;
         m_cnt = 0;
         m_rsp_valid = 0;
         m_rsp_rdata = 0;
         m_cycles = 0;
      end else if (m_init) begin
         m_cycles++;
         m_rsp_valid = 0;
         if (m_mode == M_IDLE) begin
            if (req_valid) begin
               if (req_we) begin
                  m_mem[req_addr] = int'(req_wdata);
                  m_known[req_addr] = 1;
               end else begin
                  m_rsp_valid = 1;
                  m_rsp_rdata = m_mem[req_addr];
               end
            end
            if (clr_req) begin
               m_mode = M_CLEAR;
               m_cnt = 0;
            end
         end else begin
            m_mem[m_cnt] = (m_mode == M_BOOT) ? img[m_cnt] : 0;
            m_known[m_cnt] = 1;
            m_cnt++;
            if (m_cnt == DEPTH) m_mode = M_IDLE;
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         int sa;
         sa = (m_cycles / SDIV) % DEPTH;
         chk("req_ready", req_ready, m_mode == M_IDLE);
         chk("busy", busy, m_mode != M_IDLE);
         chk("rsp_valid", rsp_valid, m_rsp_valid);
         chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
         chk("scan_addr", scan_addr, sa);
         if (m_known[sa]) chk("scan_data", scan_data, m_mem[sa]);
         for (int i = 0; i < DEPTH; i++)
            if (m_known[i]) chk($sformatf("data_output_w%0d", i), data_output[i*DW +: DW], m_mem[i]);
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic read_word(input int a, output int d);
      bit ok;
      ok = 0;
      req_valid = 1; req_we = 0; req_addr = AW'(a);
      for (int n = 0; n < 100 && !ok; n++) begin
         if (req_ready) ok = 1;
         tick();
      end
      req_valid = 0;
      if (!ok) chk("read_timeout", 0, 1);
      chk("read_rsp_valid", rsp_valid, 1);
      d = int'(rsp_rdata);
   endtask

   task automatic write_word(input int a, input int v);
      bit ok;
      ok = 0;
      req_valid = 1; req_we = 1; req_addr = AW'(a); req_wdata = DW'(v);
      for (int n = 0; n < 100 && !ok; n++) begin
         if (req_ready) ok = 1;
         tick();
      end
      req_valid = 0; req_we = 0;
      if (!ok) chk("write_timeout", 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d, n;
      logic [DEPTH*DW-1:0] img_vec;
      for (int i = 0; i < DEPTH; i++) img_vec[i*DW +: DW] = DW'(img[i]);

      // Boot timing and readback of the boot image
      rst = 1;
      tick(); tick(); tick();
      chk("reset_busy", busy, 1);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_scan_addr", scan_addr, 0);
      rst = 0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (k < 16) chk("boot_busy", busy, 1);
         else chk("boot_ready_at_16", req_ready, 1);
      end
      for (int a = 0; a < DEPTH; a++) begin
         read_word(a, d);
         chk($sformatf("boot_read_%0d", a), d, img[a]);
      end

      // Write then read-after-write
      write_word(5, 8'hA5);
      chk("dout_47_40", data_output[47:40], 8'hA5);
      read_word(5, d);
      chk("raw_read5", d, 8'hA5);

      // Request held through boot, then back-to-back reads
      rst = 1;
      req_valid = 1; req_we = 0; req_addr = 4'd3;
      tick();
      rst = 0;
      n = 0;
      while (!req_ready && n < 100) begin tick(); n++; end
      chk("held_req_wait", n, 16);
      tick();
      req_addr = 4'd4;
      chk("b2b_valid0", rsp_valid, 1);
      chk("b2b_data0", rsp_rdata, 1);
      tick();
      req_valid = 0;
      chk("b2b_valid1", rsp_valid, 1);
      chk("b2b_data1", rsp_rdata, 6);
      tick();
      chk("b2b_valid2", rsp_valid, 0);

      // Clear together with a read; clr during clear ignored
      write_word(2, 8'hFF);
      req_valid = 1; req_we = 0; req_addr = 4'd2; clr_req = 1;
      tick();
      req_valid = 0; clr_req = 0;
      chk("clr_read", rsp_rdata, 8'hFF);
      n = 0;
      while (busy && n < 100) begin
         n++;
         clr_req = (n == 5);
         tick();
      end
      clr_req = 0;
      chk("clear_busy_len", n, 16);
      chk("clear_zero", data_output, '0);

      // Reset mid-clear, boot restore and scan wrap
      clr_req = 1;
      tick();
      clr_req = 0;
      for (int k = 0; k < 7; k++) tick();
      rst = 1;
      tick();
      rst = 0;
      for (int k = 1; k <= 64; k++) begin
         tick();
         chk("rst_mid_clear_rsp", rsp_valid, 0);
         if (k == 16) chk("boot_restored", data_output, img_vec);
         if (k == 60) chk("scan_15", scan_addr, 15);
         if (k == 64) chk("scan_wrap_0", scan_addr, 0);
      end

      // Randomized traffic against the model
      for (int k = 0; k < 600; k++) begin
         req_valid = 1'($urandom_range(0, 1));
         req_we    = 1'($urandom_range(0, 1));
         req_addr  = AW'($urandom_range(0, DEPTH - 1));
         req_wdata = DW'($urandom_range(0, 255));
         clr_req   = ($urandom_range(0, 29) == 0);
         rst       = ($urandom_range(0, 199) == 0);
         tick();
      end
      req_valid = 0; clr_req = 0; rst = 0;
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
